bitwise_resp: RTL and testbench
===============================

# bitwise_resp

Streaming responder for bitwise operand pairs: accepts `(a, b, op)` on a valid/ready input channel, computes one of four bitwise operations, and returns results in order on a valid/ready output channel through a 2-entry output buffer. It is the hardware consumer of the operand streams our benches generate. It also keeps a transfer counter and, optionally, a result signature, so a bench or host can check a run without logging every result.

## Interface
- `W`, 8, operand/result width (≥2)
- `CNT_W`, 16, width of transfer counter
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  block can accept operand pair
- `in_a`  in  W  operand A
- `in_b`  in  W  operand B
- `in_op`  in  2  00 AND, 01 OR, 10 XOR, 11 XNOR
- `out_valid`  out  1  result present
- `out_ready`  in  1  downstream accepts result
- `out_y`  out  W  result
- `out_op`  out  2  opcode that produced `out_y`
- `op_count`  out  CNT_W  number of completed output transfers
- `sig`  out  W  result signature (see Configuration)

## Operation
- Input transfer: `in_valid & in_ready` at a rising edge. Output transfer: `out_valid & out_ready` at a rising edge.
- On an input transfer, the block computes `f(in_a, in_b, in_op)` and writes `{op, y}` into a 2-entry FIFO in the same edge. No combinational path from the inputs to `out_y`.
- `out_y`/`out_op` show the FIFO head. `out_valid = (occupancy != 0)`.
- `in_ready = (occupancy != 2)`. It depends only on registered state, never combinationally on `out_ready`.
- Occupancy update per edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, with both pointers advancing
  - neither: hold
- Push while full cannot occur because `in_ready` is 0. Pop while empty cannot occur because `out_valid` is 0.
- Results leave in acceptance order.
- While stalled (`out_valid & ~out_ready`), `out_y` and `out_op` are held stable.
- `op_count` increments by 1 on each output transfer and wraps modulo 2^CNT_W.
- Reset (async, any time, including mid-stream) has immediate effect:
  - FIFO emptied; in-flight results discarded, not replayed.
  - `in_ready`=1, `out_valid`=0, `out_y`=0, `out_op`=0, `op_count`=0, `sig`=0.

## Timing
- Latency: an operand accepted at edge N has its result visible after edge N, so it can transfer at edge N+1 at the earliest.
- Throughput: 1 transfer/cycle sustained when `out_ready` is held high.
- With `out_ready`=0, the block accepts exactly 2 pairs, then `in_ready`=0 after the second acceptance edge.
- `in_ready` rises on the edge after the first pop from full. There is no same-cycle pass-through.
- Async reset assertion clears state without a clock. Deassertion is sampled by the next rising edge; the first transfer is possible at that edge.

## Configuration
- Macro: `BITWISE_RESP_SIG_EN`.
- Defined:
  - On every output transfer, `sig <= {sig[W-2:0], sig[W-1]} ^ out_y` (rotate-left by 1, then XOR).
  - `sig` resets to 0 and is never cleared except by reset.
- Undefined:
  - No signature register is built.
  - `sig` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Opcode sweep: a=8'hC3, b=8'h5A, ops 00/01/10/11 back-to-back, `out_ready`=1 → outputs 8'h42, 8'hDB, 8'h99, 8'h66 in order, each one cycle after acceptance; `op_count`=4.
- Backpressure: `out_ready`=0, in_valid held with 3 distinct pairs → `in_ready` drops after 2 acceptances, 3rd held; `out_y` stable. Raise `out_ready` → 3 results in order; `in_ready` returns the cycle after the first pop.
- Simultaneous push/pop at occupancy 1 over 10 cycles with random `out_ready` → no loss, no duplication, order preserved; occupancy never exceeds 2.
- Reset mid-stream: assert `rst_n`=0 with FIFO full, no clock edge → `out_valid`=0, `in_ready`=1, `op_count`=0, `sig`=0 immediately; no old results appear after release.
- Counter wrap (CNT_W=4): 17 transfers → `op_count`=1.
- Signature (macro defined): outputs 8'h42 then 8'hDB → `sig`=8'h42, then 8'h5F. With macro undefined, `sig` stays 0.

Source files
------------

// File: rtl/bitwise_resp.sv
// Streaming bitwise responder: AND/OR/XOR/XNOR on (a, b) into a 2-entry result FIFO.
// Optional result signature register enabled by defining BITWISE_RESP_SIG_EN.
module bitwise_resp #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] op_count,
  output logic [W-1:0]     sig
);

  logic [W-1:0] mem_y  [2];
  logic [1:0]   mem_op [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   occ;
  logic         push;
  logic         pop;
  logic [W-1:0] y_new;

  always_comb begin
    y_new = '0;
    unique case (in_op)
      2'b00: y_new = in_a & in_b;
      2'b01: y_new = in_a | in_b;
      2'b10: y_new = in_a ^ in_b;
      2'b11: y_new = ~(in_a ^ in_b);
      default: y_new = '0;
    endcase
  end

  // Handshakes depend only on registered occupancy; no ready pass-through.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_y  = mem_y[rd_ptr];
  assign out_op = mem_op[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_y[0]  <= '0;
      mem_y[1]  <= '0;
      mem_op[0] <= '0;
      mem_op[1] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
    end else begin
      if (push) begin
        mem_y[wr_ptr]  <= y_new;
        mem_op[wr_ptr] <= in_op;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + 1'b1;
    end
  end

`ifdef BITWISE_RESP_SIG_EN
  logic [W-1:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (pop) begin
      sig_q <= {sig_q[W-2:0], sig_q[W-1]} ^ out_y;
    end
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_bitwise_resp.sv
// Directed self-checking bench for bitwise_resp: opcode sweep, backpressure,
// random-ready streaming, async reset mid-stream, counter wrap and signature.
module tb_bitwise_resp;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         out_ready;

  logic         in_ready, out_valid;
  logic [W-1:0] out_y, sig;
  logic [1:0]   out_op;
  logic [15:0]  op_count;

  logic         in_ready4, out_valid4;
  logic [W-1:0] out_y4, sig4;
  logic [1:0]   out_op4;
  logic [3:0]   op_count4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W+1:0] m_q[$];
  int           n_xfer = 0;
  logic [W-1:0] exp_sig = '0;

  always #5 clk = ~clk;

  bitwise_resp #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
    .op_count(op_count), .sig(sig)
  );

  bitwise_resp #(.W(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
    .out_ready(out_ready), .out_y(out_y4), .out_op(out_op4),
    .op_count(op_count4), .sig(sig4)
  );

  function automatic logic [W-1:0] ref_f(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the reference FIFO model, then sample 1 time unit after the edge.
  task automatic tick(string tag);
    bit push, pop;
    push = in_valid && (m_q.size() != 2);
    pop  = out_ready && (m_q.size() != 0);
    @(posedge clk);
    if (pop) begin
`ifdef BITWISE_RESP_SIG_EN
      exp_sig = {exp_sig[W-2:0], exp_sig[W-1]} ^ m_q[0][W-1:0];
`endif
      void'(m_q.pop_front());
      n_xfer++;
    end
    if (push) m_q.push_back({in_op, ref_f(in_a, in_b, in_op)});
    #1;
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, m_q.size() != 2});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    chk({tag, ".op_count"},  {16'd0, op_count},  n_xfer & 32'hFFFF);
    chk({tag, ".sig"},       {24'd0, sig},       {24'd0, exp_sig});
    if (m_q.size() != 0) begin
      chk({tag, ".out_y"},  {24'd0, out_y},  {24'd0, m_q[0][W-1:0]});
      chk({tag, ".out_op"}, {30'd0, out_op}, {30'd0, m_q[0][W+1:W]});
    end
  endtask

  task automatic drive(logic v, logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 2'b00);
    #12;
    chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_y",     {24'd0, out_y},     32'd0);
    chk("rst.out_op",    {30'd0, out_op},    32'd0);
    chk("rst.op_count",  {16'd0, op_count},  32'd0);
    chk("rst.sig",       {24'd0, sig},       32'd0);
    rst_n = 1'b1;

    // Opcode sweep, one cycle latency, full throughput.
    out_ready = 1'b1;
    drive(1'b1, 8'hC3, 8'h5A, 2'b00); tick("sw0");
    chk("sw0.y", {24'd0, out_y}, 32'h42);
    drive(1'b1, 8'hC3, 8'h5A, 2'b01); tick("sw1");
    chk("sw1.y", {24'd0, out_y}, 32'hDB);
`ifdef BITWISE_RESP_SIG_EN
    chk("sw1.sig_hand", {24'd0, sig}, 32'h42);
`endif
    drive(1'b1, 8'hC3, 8'h5A, 2'b10); tick("sw2");
    chk("sw2.y", {24'd0, out_y}, 32'h99);
`ifdef BITWISE_RESP_SIG_EN
    chk("sw2.sig_hand", {24'd0, sig}, 32'h5F);
`endif
    drive(1'b1, 8'hC3, 8'h5A, 2'b11); tick("sw3");
    chk("sw3.y",  {24'd0, out_y},  32'h66);
    chk("sw3.op", {30'd0, out_op}, 32'd3);
    drive(1'b0, '0, '0, 2'b00); tick("sw4");
    chk("sw4.count_hand", {16'd0, op_count}, 32'd4);
`ifndef BITWISE_RESP_SIG_EN
    chk("sw4.sig_off", {24'd0, sig}, 32'd0);
`endif

    // Backpressure: two accepted, third held, output stable.
    out_ready = 1'b0;
    drive(1'b1, 8'hF0, 8'h0F, 2'b01); tick("bp0");
    chk("bp0.y", {24'd0, out_y}, 32'hFF);
    drive(1'b1, 8'hAA, 8'h55, 2'b00); tick("bp1");
    chk("bp1.in_ready_hand", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 8'h3C, 8'h0F, 2'b10); tick("bp2");
    chk("bp2.y_stable", {24'd0, out_y}, 32'hFF);
    tick("bp3");
    chk("bp3.y_stable", {24'd0, out_y}, 32'hFF);
    out_ready = 1'b1; tick("bp4");
    chk("bp4.in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("bp4.y", {24'd0, out_y}, 32'h00);
    tick("bp5");
    chk("bp5.y", {24'd0, out_y}, 32'h33);
    drive(1'b0, '0, '0, 2'b00); tick("bp6");
    chk("bp6.count_hand", {16'd0, op_count}, 32'd7);

    // Streaming with random out_ready starting from occupancy 1.
    out_ready = 1'b0;
    drive(1'b1, 8'h81, 8'h7E, 2'b11); tick("rs_pre");
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive(1'b1, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
      tick("rs");
    end
    drive(1'b0, '0, '0, 2'b00);
    out_ready = 1'b1;
    tick("rs_drain"); tick("rs_drain"); tick("rs_drain");

    // Fill FIFO, then async reset with no clock edge.
    out_ready = 1'b0;
    drive(1'b1, 8'h12, 8'h34, 2'b01); tick("mr0");
    drive(1'b1, 8'h56, 8'h78, 2'b10); tick("mr1");
    drive(1'b0, '0, '0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr.in_ready",  {31'd0, in_ready},  32'd1);
    chk("mr.op_count",  {16'd0, op_count},  32'd0);
    chk("mr.sig",       {24'd0, sig},       32'd0);
    chk("mr.out_y",     {24'd0, out_y},     32'd0);
    m_q.delete();
    n_xfer  = 0;
    exp_sig = '0;
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick("mr_post"); tick("mr_post");

    // Counter wrap on the CNT_W=4 instance: 17 transfers.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i * 13 + 1), 8'(i * 7), 2'(i));
      tick("wr");
    end
    drive(1'b0, '0, '0, 2'b00); tick("wr_end");
    chk("wr.count4", {28'd0, op_count4}, 32'd1);
    chk("wr.count16", {16'd0, op_count}, 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
